write_ptr_handler: RTL and testbench

- Write-domain pointer and status logic for the async FIFO.
- Counterpart of the read-side pointer handler.
- Owns the binary and Gray write pointers and the registered full flag.
- Also provides a conservative fill level, almost_full and a sticky overflow flag.
- Consumes the read Gray pointer after it has been synchronised into wclk; emits the Gray write pointer for synchronisation into the read domain.

---
 rtl/write_ptr_handler_if.sv | 41 ++++
 rtl/write_ptr_handler.sv | 86 ++++++++
 tb/tb_write_ptr_handler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/write_ptr_handler_if.sv
// rtl/write_ptr_handler_if.sv - write-side pointer/status bundle for the async FIFO write domain
//
// Purpose: groups the write request, synchronised read pointer, overflow clear
// and all write-side pointer/status outputs of write_ptr_handler.
// Ports (signals):
//   w_en         write request                     (master -> slave)
//   g_rptr_sync  read Gray pointer, in wclk domain (master -> slave)
//   ovf_clr      clears the sticky overflow flag   (master -> slave)
//   g_wptr       registered Gray write pointer     (slave -> master)
//   b_wptr       registered binary write pointer   (slave -> master)
//   waddr        memory write address              (slave -> master)
//   w_accept     memory write enable               (slave -> master)
//   full         registered full flag              (slave -> master)
//   almost_full  registered almost-full flag       (slave -> master)
//   wlevel       registered write-side occupancy   (slave -> master)
//   overflow     sticky write-while-full flag      (slave -> master)
interface write_ptr_handler_if #(
    parameter int ptr_width = 6
);
    logic                   w_en;
    logic [ptr_width-1:0]   g_rptr_sync;
    logic                   ovf_clr;
    logic [ptr_width-1:0]   g_wptr;
    logic [ptr_width-1:0]   b_wptr;
    logic [ptr_width-2:0]   waddr;
    logic                   w_accept;
    logic                   full;
    logic                   almost_full;
    logic [ptr_width-1:0]   wlevel;
    logic                   overflow;

    modport master (
        output w_en, g_rptr_sync, ovf_clr,
        input  g_wptr, b_wptr, waddr, w_accept, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  w_en, g_rptr_sync, ovf_clr,
        output g_wptr, b_wptr, waddr, w_accept, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/write_ptr_handler.sv
// rtl/write_ptr_handler.sv - async FIFO write-domain pointer, full/level and overflow logic
//
// Purpose: owns the binary and Gray write pointers, the registered full flag,
// a conservative fill level, almost_full and a sticky overflow flag.
// Ports:
//   wclk    write clock
//   wrst_n  asynchronous active-low reset
//   wif     write_ptr_handler_if.slave (see interface header for signals)
module write_ptr_handler #(
    parameter int ptr_width = 6,
    parameter int af_thresh = 28
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    write_ptr_handler_if.slave    wif
);

    logic [ptr_width-1:0] b_wptr_q, b_wptr_d;
    logic [ptr_width-1:0] g_wptr_q, g_wptr_d;
    logic [ptr_width-1:0] wlevel_q, wlevel_d;
    logic                 full_q, full_d;
    logic                 almost_full_q, almost_full_d;
    logic                 overflow_q, overflow_d;
    logic                 w_accept;
    logic [ptr_width-1:0] b_rptr_sync;
    logic [ptr_width-1:0] g_rptr_full_cmp;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ptr_width-1:0] gray2bin(input logic [ptr_width-1:0] g);
        logic [ptr_width-1:0] b;
        b[ptr_width-1] = g[ptr_width-1];
        for (int i = ptr_width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        w_accept    = wif.w_en & ~full_q;
        b_wptr_d    = b_wptr_q + {{(ptr_width-1){1'b0}}, w_accept};
        g_wptr_d    = b_wptr_d ^ (b_wptr_d >> 1);
        b_rptr_sync = gray2bin(wif.g_rptr_sync);

        // In Gray code, "writer exactly one lap ahead" means the two MSBs differ
        // from the read pointer and all lower bits match.
        g_rptr_full_cmp = {~wif.g_rptr_sync[ptr_width-1:ptr_width-2],
                           wif.g_rptr_sync[ptr_width-3:0]};
        full_d          = (g_wptr_d == g_rptr_full_cmp);

        // Uses the lagging synchronised read pointer, so the level can only
        // overestimate occupancy.
        wlevel_d      = b_wptr_d - b_rptr_sync;
        almost_full_d = (int'(wlevel_d) >= af_thresh);

        // A set on the same edge as a clear wins.
        overflow_d = (wif.w_en & full_q) | (overflow_q & ~wif.ovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr_q      <= '0;
            g_wptr_q      <= '0;
            wlevel_q      <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            b_wptr_q      <= b_wptr_d;
            g_wptr_q      <= g_wptr_d;
            wlevel_q      <= wlevel_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wif.g_wptr      = g_wptr_q;
    assign wif.b_wptr      = b_wptr_q;
    assign wif.waddr       = b_wptr_q[ptr_width-2:0];
    assign wif.w_accept    = w_accept;
    assign wif.full        = full_q;
    assign wif.almost_full = almost_full_q;
    assign wif.wlevel      = wlevel_q;
    assign wif.overflow    = overflow_q;

endmodule

// File: tb/tb_write_ptr_handler.sv
// tb/tb_write_ptr_handler.sv - scoreboard bench for write_ptr_handler
module tb_write_ptr_handler;

    localparam int PW    = 6;
    localparam int DEPTH = 32;
    localparam int AF    = 28;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b1;

    write_ptr_handler_if #(.ptr_width(PW)) wif ();

    write_ptr_handler #(.ptr_width(PW), .af_thresh(AF)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .wif    (wif)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic          acc;
        logic [PW-2:0] waddr;
        logic [PW-1:0] b;
        logic [PW-1:0] g;
        logic [PW-1:0] lvl;
        logic          full;
        logic          af;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: total accepted writes and total reads as plain counts.
    int wcount = 0;
    int rcount = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs (caller is in the slot just after a negedge)
    // and push the model's expectation for the coming edge.
    task automatic apply(input bit we, input bit clr);
        exp_t e;
        bit   acc;
        int   lvl;
        wif.w_en        = we;
        wif.ovf_clr     = clr;
        wif.g_rptr_sync = gray(PW'(rcount % 64));
        acc     = we && !m_full;
        e.acc   = acc;
        e.waddr = (PW-1)'(wcount % DEPTH);
        m_ovf   = (we && m_full) || (m_ovf && !clr);
        wcount  = wcount + (acc ? 1 : 0);
        lvl     = wcount - rcount;
        m_full  = (lvl == DEPTH);
        e.b     = PW'(wcount % 64);
        e.g     = gray(PW'(wcount % 64));
        e.lvl   = PW'(lvl);
        e.full  = m_full;
        e.af    = (lvl >= AF);
        e.ovf   = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic step(input bit we, input bit clr);
        @(negedge wclk);
        #1;
        apply(we, clr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_b_wptr"},   int'(wif.b_wptr),      0);
        chk({tag, "_g_wptr"},   int'(wif.g_wptr),      0);
        chk({tag, "_full"},     int'(wif.full),        0);
        chk({tag, "_af"},       int'(wif.almost_full), 0);
        chk({tag, "_wlevel"},   int'(wif.wlevel),      0);
        chk({tag, "_overflow"}, int'(wif.overflow),    0);
        chk({tag, "_waddr"},    int'(wif.waddr),       0);
    endtask

    // Asserts reset between edges with w_en held high, checks outputs clear
    // at once and stay clear, then releases and applies a write.
    task automatic reset_cycle(input string tag);
        wrst_n  = 1'b0;
        wif.w_en = 1'b1;
        #1;
        chk_zero({tag, "_async"});
        repeat (2) @(posedge wclk);
        #1;
        chk_zero({tag, "_held"});
        wcount = 0;
        rcount = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        @(negedge wclk);
        #1;
        wrst_n = 1'b1;
        apply(1'b1, 1'b0);
    endtask

    // Monitor: at negedge+2 pops the expectation for the coming edge and
    // checks the combinational outputs; at the following negedge checks the
    // registered outputs.
    exp_t cur;
    bit   pending = 1'b0;

    initial begin
        forever begin
            @(negedge wclk);
            if (pending) begin
                chk("b_wptr",      int'(wif.b_wptr),      int'(cur.b));
                chk("g_wptr",      int'(wif.g_wptr),      int'(cur.g));
                chk("wlevel",      int'(wif.wlevel),      int'(cur.lvl));
                chk("full",        int'(wif.full),        int'(cur.full));
                chk("almost_full", int'(wif.almost_full), int'(cur.af));
                chk("overflow",    int'(wif.overflow),    int'(cur.ovf));
                pending = 1'b0;
            end
            #2;
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                chk("w_accept", int'(wif.w_accept), int'(cur.acc));
                chk("waddr",    int'(wif.waddr),    int'(cur.waddr));
                pending = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int phase_rd;
        wif.w_en        = 1'b0;
        wif.ovf_clr     = 1'b0;
        wif.g_rptr_sync = '0;
        #2;

        // Reset with w_en held, then first edge after release writes entry 0.
        reset_cycle("rst0");

        // Fill to full with read pointer at 0 (31 more writes).
        repeat (DEPTH - 1) step(1'b1, 1'b0);

        // Writes while full, clear, then set/clear on the same edge.
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Read pointer advances by one: full drops, next write refills.
        rcount = 1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Wrap: reader trails by 4 while 70 writes pass the 63 -> 0 boundary.
        repeat (70) begin
            rcount = wcount - 4;
            step(1'b1, 1'b0);
        end

        // Randomized traffic with alternating slow/fast reader phases.
        for (int i = 0; i < 1500; i++) begin
            int room;
            int adv;
            phase_rd = ((i / 150) % 2 == 0) ? 4 : 1;
            room = wcount - rcount;
            adv  = ($urandom_range(0, phase_rd) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (adv > room) adv = room;
            rcount = rcount + adv;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        // Build up b_wptr = 20 with overflow set, then reset mid-stream.
        for (int i = 0; i < 40 && !m_full; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 70 && (wcount % 64) != 20; i++) begin
            rcount = wcount - 4;
            step(1'b1, 1'b0);
        end
        @(negedge wclk);
        #1;
        chk("pre_rst_b_wptr",   int'(wif.b_wptr),   20);
        chk("pre_rst_overflow", int'(wif.overflow), 1);
        reset_cycle("rst_mid");
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        repeat (3) @(negedge wclk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
